// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the memory stage (master) and the data memory (slave).
interface dmem_if;
   import dmem_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [WORD_W-1:0] req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic [BE_W-1:0]   req_be;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WORD_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-enabled write, asynchronous read, cleared on reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   input  logic [BE_W-1:0]   be,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
               mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target with valid/ready request and response channels and programmable wait states.
// Optional DMEM_BYTE_EN_EN: stores honour the byte enables; otherwise every legal store writes the full word.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   dmem_if.slave bus
);

   localparam int          IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LO    = {1'b0, BASE_ADDR};
   localparam logic [32:0] HI    = LO + 33'(DEPTH_WORDS * 4);

   dmem_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              we_q;
   logic [WORD_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic [BE_W-1:0]   be_q;
   logic              rsp_valid_q;
   logic [WORD_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;

   logic              addr_err;
   logic              access;
   logic              mem_we;
   logic [BE_W-1:0]   mem_be;
   logic [IDX_W-1:0]  mem_idx;
   logic [WORD_W-1:0] mem_rdata;

   // Range check is done in 33 bits so an address near the top of the space cannot wrap into range.
   assign addr_err = (addr_q[1:0] != 2'b00) ||
                     ({1'b0, addr_q} < LO)  ||
                     ({1'b0, addr_q} >= HI);
   assign mem_idx  = IDX_W'((addr_q - BASE_ADDR) >> 2);
   assign access   = (state_q == BUSY) && (cnt_q == '0);
   assign mem_we   = access && we_q && !addr_err;

`ifdef DMEM_BYTE_EN_EN
   assign mem_be = be_q;
`else
   assign mem_be = '1;
`endif

   dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .we    (mem_we),
      .idx   (mem_idx),
      .wdata (wdata_q),
      .be    (mem_be),
      .rdata (mem_rdata)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req_valid) state_d = BUSY;
         BUSY:    if (cnt_q == '0)   state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch, wait counter and registered response; the response holds until handshaken.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q    <= bus.req_we;
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  be_q    <= bus.req_be;
                  cnt_q   <= CNT_W'(WAIT_CYCLES);
               end
            end
            BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= (we_q || addr_err) ? '0 : mem_rdata;
                  rsp_err_q   <= addr_err;
               end
            end
            RESP: begin
               if (bus.rsp_ready) rsp_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule
